uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The module SHALL have parameter CLOCK_FREQ, default 12000000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 19200, meaning the line rate in bit/s.
REQ-003 The module SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit (even, 8..32).
REQ-004 The module SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (5..9).
REQ-005 The module SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-006 The module SHALL have parameter STOP_BITS, default 1, meaning stop bits checked (1 or 2).
REQ-007 The module SHALL have parameter FIFO_DEPTH, default 4, meaning output words buffered (power of two, 2..16).
REQ-008 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-009 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-010 The module SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-011 The module SHALL have port enable, input, 1 bit: permits start-bit detection.
REQ-012 The module SHALL have port data, output, DATA_BITS bits: head-of-FIFO payload.
REQ-013 The module SHALL have port frame_err, output, 1 bit: head word had a low stop bit.
REQ-014 The module SHALL have port parity_err, output, 1 bit: head word failed the parity check.
REQ-015 The module SHALL have port valid, output, 1 bit: FIFO non-empty.
REQ-016 The module SHALL have port ready, input, 1 bit: consumer accepts the head word.
REQ-017 The module SHALL have port overrun, output, 1 bit: sticky flag, a word was dropped on a full FIFO.
REQ-018 The module SHALL have port clr_overrun, input, 1 bit: synchronous clear of overrun.
REQ-019 The module SHALL have port busy, output, 1 bit: a frame is being received.

Function
REQ-020 rxd SHALL pass through a 2-flop synchroniser whose flops reset to 1, and all logic SHALL use the synchronised value.
REQ-021 The tick divider SHALL pulse one clk every DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) cycles (truncating), and SHALL restart at 0 on start-bit detection.
REQ-022 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, BREAK, and busy SHALL be 1 in every state except IDLE.
REQ-023 In IDLE, a 1->0 edge on synchronised rxd with enable=1 SHALL enter START; if enable=0, the FSM SHALL stay in IDLE.
REQ-024 Each bit SHALL be decided by a 2-of-3 majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit; the FSM SHALL advance to the next bit after OVERSAMPLE ticks.
REQ-025 A start bit decided as 1 SHALL be a false start: return to IDLE with no FIFO write.
REQ-026 DATA SHALL capture DATA_BITS bits, LSB first; it SHALL go to PARITY if PARITY != 0, otherwise to STOP.
REQ-027 parity_err SHALL be 1 when the XOR of the data bits and the parity bit is 0 for odd parity or 1 for even parity, and SHALL be 0 when PARITY=0.
REQ-028 frame_err SHALL be 1 if any checked stop bit is decided 0.
REQ-029 The word SHALL be pushed at the decision tick of the last stop bit; valid SHALL rise on the following clk edge when the FIFO was empty.
REQ-030 After the push, the FSM SHALL return to IDLE without waiting for the end of the stop bit, so back-to-back frames resynchronise.
REQ-031 If all data bits are 0 and the first stop bit is 0 (break), the word SHALL be pushed with frame_err=1, and the FSM SHALL enter BREAK and remain there until synchronised rxd is 1.
REQ-032 A pop SHALL occur when valid=1 and ready=1; data, frame_err and parity_err SHALL stay stable while valid=1 and ready=0.
REQ-033 A push on a full FIFO with no pop in the same cycle SHALL drop the new word and set overrun; the FIFO contents SHALL be unchanged.
REQ-034 A push on a full FIFO with a pop in the same cycle SHALL be accepted.
REQ-035 A simultaneous push and pop on an empty FIFO SHALL NOT bypass: valid SHALL rise on the next cycle.
REQ-036 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-037 clr_overrun SHALL clear overrun; if clr_overrun and an overrun event occur in the same cycle, overrun SHALL end the cycle set.
REQ-038 Deasserting enable mid-frame SHALL NOT abort the frame; enable is sampled only in IDLE.

Reset
REQ-039 While rst=0, the block SHALL hold FSM=IDLE, FIFO empty, valid=0, busy=0, overrun=0, data=0, frame_err=0, parity_err=0, synchroniser=1, and tick counter=0.
REQ-040 A reset mid-frame SHALL discard the partial frame and all buffered words; after release, the block SHALL need a fresh 1->0 edge to start.

Verification (CLOCK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16 -> 160 clk/bit)
REQ-041 With 8N1, send 0xA5 with ready=1 -> data=0xA5, valid high for 1 cycle, both error flags 0, busy falls after the stop-bit decision.
REQ-042 With PARITY=2, send 0x07 with parity bit 0 -> parity_err=1; with the correct parity bit 1 -> parity_err=0.
REQ-043 Hold a 40-clk low glitch on idle rxd -> no word pushed and busy returns to 0.
REQ-044 Send a break (rxd low for 12 bit times) -> one word pushed with data=0x00 and frame_err=1, and no further words until rxd returns high.
REQ-045 With FIFO_DEPTH=4, ready=0, send 5 frames -> the first 4 are retained and overrun=1; pulse clr_overrun -> overrun=0; then ready=1 -> words pop in order.
REQ-046 Assert rst=0 during DATA bit 3 -> all outputs take their reset values immediately, and the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with majority voting, parity/stop checks, break detection and an output FIFO.
// Ports: clk clock; rst async active-low reset; rxd serial line (idle high); enable permits start detection;
//        data/frame_err/parity_err head-of-FIFO word; valid FIFO non-empty; ready consumer pop;
//        overrun sticky drop flag; clr_overrun clears it; busy frame in progress.
module uart_rx_cfg #(
  parameter int CLOCK_FREQ = 12000000,
  parameter int BAUD_RATE  = 19200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 enable,
  output logic [DATA_BITS-1:0] data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic                 busy
);
  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WW  = DATA_BITS + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t               r_state, w_next;
  logic [1:0]           r_sync;
  logic                 r_rx_d;
  logic [DW-1:0]        r_div;
  logic [TW-1:0]        r_tcnt;
  logic [3:0]           r_bitcnt;
  logic [1:0]           r_smp;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par, r_ferr, r_ovr;
  logic [WW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wp, r_rp;
  logic [AW:0]          r_cnt;

  logic w_rx, w_fall, w_start, w_tick, w_dec, w_end, w_bit, w_dlast, w_slast;
  logic w_brk, w_push, w_perr, w_full, w_pop, w_wr, w_ovr;
  logic [WW-1:0] w_word;

  assign w_rx    = r_sync[1];
  assign w_fall  = r_rx_d & ~w_rx;
  assign w_start = (r_state == S_IDLE) & enable & w_fall;
  assign w_tick  = r_div == DW'(DIV - 1);
  // third sample tick is where the bit is decided; last tick of the bit advances
  assign w_dec   = w_tick & (r_tcnt == TW'(OVERSAMPLE / 2 + 1));
  assign w_end   = w_tick & (r_tcnt == TW'(OVERSAMPLE - 1));
  assign w_bit   = (r_smp[0] & r_smp[1]) | (w_rx & (r_smp[0] | r_smp[1]));
  assign w_dlast = r_bitcnt == 4'(DATA_BITS - 1);
  assign w_slast = r_bitcnt == 4'(STOP_BITS - 1);
  // all-zero data with a low first stop bit is a break
  assign w_brk   = (r_state == S_STOP) & w_dec & (r_bitcnt == 4'd0) & ~w_bit & ~|r_shift;
  assign w_push  = (r_state == S_STOP) & w_dec & (w_slast | w_brk);
  assign w_perr  = PARITY == 0 ? 1'b0 : ^{r_shift, r_par, PARITY == 1};
  assign w_word  = {w_perr, r_ferr | ~w_bit, r_shift};
  assign w_full  = r_cnt == (AW + 1)'(FIFO_DEPTH);
  assign w_pop   = valid & ready;
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_ovr   = w_push & w_full & ~w_pop;

  assign valid = r_cnt != '0;
  assign {parity_err, frame_err, data} = valid ? r_mem[r_rp] : '0;
  assign busy    = r_state != S_IDLE;
  assign overrun = r_ovr;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_START;
      S_START:  if (w_dec & w_bit) w_next = S_IDLE; else if (w_end) w_next = S_DATA;
      S_DATA:   if (w_end & w_dlast) w_next = PARITY != 0 ? S_PARITY : S_STOP;
      S_PARITY: if (w_end) w_next = S_STOP;
      S_STOP:   if (w_brk) w_next = S_BREAK; else if (w_push) w_next = S_IDLE;
      S_BREAK:  if (w_rx) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync   <= 2'b11;
      r_rx_d   <= 1'b1;
      r_div    <= '0;
      r_tcnt   <= '0;
      r_bitcnt <= '0;
      r_smp    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_ferr   <= 1'b0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_ovr    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rxd};
      r_rx_d <= w_rx;
      r_div  <= (w_start | w_tick) ? '0 : r_div + 1'b1;
      if (w_start) r_tcnt <= '0;
      else if (w_tick) r_tcnt <= w_end ? '0 : r_tcnt + 1'b1;
      if (w_tick & (r_tcnt == TW'(OVERSAMPLE / 2 - 1))) r_smp[0] <= w_rx;
      if (w_tick & (r_tcnt == TW'(OVERSAMPLE / 2))) r_smp[1] <= w_rx;
      if (w_start) begin
        r_bitcnt <= '0;
        r_ferr   <= 1'b0;
      end else begin
        if (w_end & ((r_state == S_DATA) | (r_state == S_STOP)))
          r_bitcnt <= ((r_state == S_DATA) & w_dlast) ? 4'd0 : r_bitcnt + 4'd1;
        if ((r_state == S_STOP) & w_dec & ~w_bit) r_ferr <= 1'b1;
      end
      if ((r_state == S_DATA) & w_dec) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
      if ((r_state == S_PARITY) & w_dec) r_par <= w_bit;
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW + 1)'(w_wr) - (AW + 1)'(w_pop);
      r_ovr <= (r_ovr & ~clr_overrun) | w_ovr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= w_word;
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg, an 8N1 instance and an 8E1 instance at 160 clk per bit.
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  logic rst, rxd0, rxd1, en0, en1, rdy0, rdy1, clr0, clr1;
  logic [7:0] data0, data1;
  logic fe0, pe0, v0, ov0, busy0, fe1, pe1, v1, ov1, busy1;
  logic [9:0] q0[$], q1[$];
  int nvec = 0, nerr = 0, vc0 = 0, base;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .rxd(rxd0), .enable(en0), .data(data0), .frame_err(fe0),
    .parity_err(pe0), .valid(v0), .ready(rdy0), .overrun(ov0), .clr_overrun(clr0), .busy(busy0));

  uart_rx_cfg #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .rxd(rxd1), .enable(en1), .data(data1), .frame_err(fe1),
    .parity_err(pe1), .valid(v1), .ready(rdy1), .overrun(ov1), .clr_overrun(clr1), .busy(busy1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic b);
    if (sel) rxd1 = b;
    else rxd0 = b;
  endtask

  task automatic send(input bit sel, input logic [9:0] pl, input int n);
    drive(sel, 1'b0);
    step(160);
    for (int i = 0; i < n; i++) begin
      drive(sel, pl[i]);
      step(160);
    end
    drive(sel, 1'b1);
    step(160);
  endtask

  task automatic mon0();
    forever begin
      @(negedge clk);
      if (rst && v0 && rdy0) begin
        if (q0.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL u0 unexpected word: got %0h expected none", {pe0, fe0, data0});
        end else chk("u0 word", {pe0, fe0, data0}, q0.pop_front());
      end
    end
  endtask

  task automatic mon1();
    forever begin
      @(negedge clk);
      if (rst && v1 && rdy1) begin
        if (q1.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL u1 unexpected word: got %0h expected none", {pe1, fe1, data1});
        end else chk("u1 word", {pe1, fe1, data1}, q1.pop_front());
      end
    end
  endtask

  task automatic vcount();
    forever begin
      @(negedge clk);
      if (v0) vc0++;
    end
  endtask

  initial begin
    rst = 1'b0; rxd0 = 1'b1; rxd1 = 1'b1; en0 = 1'b1; en1 = 1'b1;
    rdy0 = 1'b1; rdy1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    fork
      mon0();
      mon1();
      vcount();
    join_none
    step(5);
    chk("reset valid", v0, 0);
    chk("reset busy", busy0, 0);
    chk("reset overrun", ov0, 0);
    chk("reset data/flags", {pe0, fe0, data0}, 0);
    chk("reset u1 valid", v1, 0);
    rst = 1'b1;
    step(5);
    // 8N1 frame 0xA5
    base = vc0;
    q0.push_back({2'b00, 8'hA5});
    fork
      send(1'b0, 10'h0A5, 8);
      begin step(800); chk("busy mid-frame", busy0, 1); end
    join
    chk("busy after A5", busy0, 0);
    chk("A5 valid cycles", vc0 - base, 1);
    // even parity: wrong then correct parity bit
    q1.push_back({2'b10, 8'h07});
    send(1'b1, {2'b00, 8'h07}, 9);
    q1.push_back({2'b00, 8'h07});
    send(1'b1, {2'b01, 8'h07}, 9);
    // 40-clk glitch is a false start
    base = vc0;
    rxd0 = 1'b0;
    step(20);
    chk("busy during glitch", busy0, 1);
    step(20);
    rxd0 = 1'b1;
    step(200);
    chk("busy after glitch", busy0, 0);
    chk("glitch words", vc0 - base, 0);
    // enable low blocks start detection
    en0 = 1'b0;
    base = vc0;
    send(1'b0, 10'h00F, 8);
    chk("enable=0 words", vc0 - base, 0);
    chk("enable=0 busy", busy0, 0);
    en0 = 1'b1;
    step(10);
    // break: 12 bit times low
    base = vc0;
    q0.push_back({2'b01, 8'h00});
    rxd0 = 1'b0;
    step(1920);
    chk("busy in break", busy0, 1);
    chk("break words", vc0 - base, 1);
    rxd0 = 1'b1;
    step(320);
    chk("busy after break", busy0, 0);
    chk("break words after release", vc0 - base, 1);
    // overrun with ready low
    rdy0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) q0.push_back({2'b00, 8'(k * 8'h11)});
      send(1'b0, {2'b00, 8'(k * 8'h11)}, 8);
    end
    chk("overrun set", ov0, 1);
    chk("head held", data0, 8'h11);
    chk("valid while full", v0, 1);
    clr0 = 1'b1;
    step(1);
    clr0 = 1'b0;
    chk("overrun cleared", ov0, 0);
    rdy0 = 1'b1;
    step(10);
    chk("drained valid", v0, 0);
    chk("drained queue", q0.size(), 0);
    // reset during data bit 3
    rdy0 = 1'b0;
    q0.push_back({2'b00, 8'h99});
    send(1'b0, 10'h099, 8);
    chk("buffered before reset", v0, 1);
    fork
      send(1'b0, 10'h03C, 8);
      begin
        step(160 * 4 + 80);
        rst = 1'b0;
        q0.delete();
        #1;
        chk("midreset valid", v0, 0);
        chk("midreset busy", busy0, 0);
        chk("midreset data", {pe0, fe0, data0}, 0);
      end
    join
    step(5);
    rst = 1'b1;
    rdy0 = 1'b1;
    step(100);
    chk("post-reset valid", v0, 0);
    chk("post-reset busy", busy0, 0);
    q0.push_back({2'b00, 8'h5A});
    send(1'b0, 10'h05A, 8);
    step(20);
    chk("u0 queue empty", q0.size(), 0);
    chk("u1 queue empty", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
